// File: rtl/wdt_controller.sv
// -----------------------------------------------------------------------------
// wdt_controller
//
// Window-watchdog sequencer for the safety-reset path. It supervises software
// kicks against a latched timeout and an "earliest legal kick" window. On a
// violation it raises WDFAIL towards the reset-pulse downcounter and waits for
// the downcounter's RSTOUT pulse. After RSTOUT has been low for HOLDOFF
// consecutive cycles it re-arms with freshly sampled config, or returns to IDLE
// when EN is low.
//
// Parameters
//   CW       width of the TIMEOUT / WIN_OPEN / RST_LMT fields and tick counter
//   HOLDOFF  consecutive RSTOUT_IN-low cycles required before re-arming
//   ACK_TMO  maximum cycles spent in FAIL waiting for RSTOUT_IN to rise
//
// Ports
//   CLK         system clock, rising edge
//   RST         synchronous active-high reset, dominates all other inputs
//   EN          watchdog enable (level)
//   KICK        single-cycle service strobe
//   TIMEOUT     kick deadline in cycles, sampled on arm
//   WIN_OPEN    earliest legal kick tick, sampled on arm (0 = no window)
//   RST_LMT_IN  reset pulse length request, sampled on arm
//   RSTOUT_IN   RSTOUT feedback from the downcounter
//   WDFAIL      fail request to the downcounter
//   RST_LMT     latched pulse length to the downcounter
//   STATE       00 IDLE, 01 ARMED, 10 FAIL, 11 HOLDOFF
//   FAIL_CAUSE  00 none, 01 timeout, 10 early kick, 11 no ack
//   FAIL_CNT    saturating count of FAIL entries
//   CFG_ERR     sticky flag: last arm attempt was refused for bad config
// -----------------------------------------------------------------------------
module wdt_controller #(
    parameter int CW      = 16,
    parameter int HOLDOFF = 4,
    parameter int ACK_TMO = 1024
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic          KICK,
    input  logic [CW-1:0] TIMEOUT,
    input  logic [CW-1:0] WIN_OPEN,
    input  logic [CW-1:0] RST_LMT_IN,
    input  logic          RSTOUT_IN,
    output logic          WDFAIL,
    output logic [CW-1:0] RST_LMT,
    output logic [1:0]    STATE,
    output logic [1:0]    FAIL_CAUSE,
    output logic [7:0]    FAIL_CNT,
    output logic          CFG_ERR
);

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int AW = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);
    localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TMO - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_FAIL  = 2'b10,
        S_HOLD  = 2'b11
    } state_t;

    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
    localparam logic [1:0] CAUSE_EARLY   = 2'b10;
    localparam logic [1:0] CAUSE_NOACK   = 2'b11;

    state_t        state;
    logic [CW-1:0] tick;
    logic [CW-1:0] to_lat;
    logic [CW-1:0] win_lat;
    logic [HW-1:0] hold_cnt;
    logic [AW-1:0] ack_cnt;

    logic cfg_ok;
    logic hold_done;
    logic arm_try;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A zero timeout could never be serviced, and a window opening at or
    // after the deadline leaves no legal kick slot.
    assign cfg_ok    = (TIMEOUT != '0) && (WIN_OPEN < TIMEOUT);
    assign hold_done = (state == S_HOLD) && !RSTOUT_IN && (hold_cnt == HOLD_LAST);
    assign arm_try   = EN && ((state == S_IDLE) || hold_done);

    assign STATE = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            WDFAIL     <= 1'b0;
            RST_LMT    <= '0;
            FAIL_CAUSE <= 2'b00;
            FAIL_CNT   <= 8'd0;
            CFG_ERR    <= 1'b0;
            tick       <= '0;
            hold_cnt   <= '0;
            ack_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tick <= '0;
                end

                S_ARMED: begin
                    if (!EN) begin
                        state <= S_IDLE;
                        tick  <= '0;
                    end else if (KICK && (tick < win_lat)) begin
                        state      <= S_FAIL;
                        WDFAIL     <= 1'b1;
                        FAIL_CAUSE <= CAUSE_EARLY;
                        FAIL_CNT   <= sat_inc8(FAIL_CNT);
                        ack_cnt    <= '0;
                        tick       <= '0;
                    end else if (KICK) begin
                        tick <= '0;
                    end else if (tick == (to_lat - CW'(1))) begin
                        state      <= S_FAIL;
                        WDFAIL     <= 1'b1;
                        FAIL_CAUSE <= CAUSE_TIMEOUT;
                        FAIL_CNT   <= sat_inc8(FAIL_CNT);
                        ack_cnt    <= '0;
                        tick       <= '0;
                    end else begin
                        tick <= tick + CW'(1);
                    end
                end

                // EN is deliberately not looked at here: once raised, a fail
                // always runs to completion.
                S_FAIL: begin
                    if (RSTOUT_IN) begin
                        WDFAIL   <= 1'b0;
                        state    <= S_HOLD;
                        hold_cnt <= '0;
                    end else if (ack_cnt == ACK_LAST) begin
                        WDFAIL     <= 1'b0;
                        FAIL_CAUSE <= CAUSE_NOACK;
                        state      <= S_HOLD;
                        hold_cnt   <= '0;
                    end else begin
                        ack_cnt <= ack_cnt + AW'(1);
                    end
                end

                S_HOLD: begin
                    if (RSTOUT_IN) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (!EN) begin
                            state <= S_IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    WDFAIL <= 1'b0;
                end
            endcase

            // Arming is shared by IDLE and the end of HOLDOFF; it overrides
            // the state update made above for those cases.
            if (arm_try) begin
                if (cfg_ok) begin
                    to_lat  <= TIMEOUT;
                    win_lat <= WIN_OPEN;
                    RST_LMT <= RST_LMT_IN;
                    CFG_ERR <= 1'b0;
                    tick    <= '0;
                    state   <= S_ARMED;
                end else begin
                    CFG_ERR <= 1'b1;
                    state   <= S_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_wdt_controller.sv
// -----------------------------------------------------------------------------
// tb_wdt_controller
//
// Directed bench for wdt_controller. A small behavioural downcounter can
// answer WDFAIL with an RST_LMT-cycle RSTOUT pulse; otherwise RSTOUT_IN is
// driven directly. ACK_TMO is shortened so the saturation run stays short.
// -----------------------------------------------------------------------------
module tb_wdt_controller;

    localparam int CW      = 16;
    localparam int HOLDOFF = 4;
    localparam int ACK_TMO = 64;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ARMED = 2'b01;
    localparam logic [1:0] ST_FAIL  = 2'b10;
    localparam logic [1:0] ST_HOLD  = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          kick;
    logic [CW-1:0] timeout;
    logic [CW-1:0] win_open;
    logic [CW-1:0] rst_lmt_in;
    logic          rstout_in;
    logic          wdfail;
    logic [CW-1:0] rst_lmt;
    logic [1:0]    state;
    logic [1:0]    fail_cause;
    logic [7:0]    fail_cnt;
    logic          cfg_err;

    logic          dc_en;
    logic          dc_out;
    logic          rstout_drv;
    logic [CW-1:0] dc_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wdt_controller #(
        .CW      (CW),
        .HOLDOFF (HOLDOFF),
        .ACK_TMO (ACK_TMO)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .EN         (en),
        .KICK       (kick),
        .TIMEOUT    (timeout),
        .WIN_OPEN   (win_open),
        .RST_LMT_IN (rst_lmt_in),
        .RSTOUT_IN  (rstout_in),
        .WDFAIL     (wdfail),
        .RST_LMT    (rst_lmt),
        .STATE      (state),
        .FAIL_CAUSE (fail_cause),
        .FAIL_CNT   (fail_cnt),
        .CFG_ERR    (cfg_err)
    );

    // Downcounter model: on seeing WDFAIL, drive RSTOUT high for RST_LMT cycles.
    assign rstout_in = dc_en ? dc_out : rstout_drv;

    always @(posedge clk) begin
        if (rst || !dc_en) begin
            dc_out <= 1'b0;
            dc_cnt <= '0;
        end else if (dc_out) begin
            if (dc_cnt < CW'(2)) dc_out <= 1'b0;
            else                 dc_cnt <= dc_cnt - CW'(1);
        end else if (wdfail) begin
            dc_out <= 1'b1;
            dc_cnt <= rst_lmt;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        en   = 1'b0;
        kick = 1'b0;
        step();
        rst  = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_state"},   32'(state),      32'(ST_IDLE));
        check({pfx, "_wdfail"},  32'(wdfail),     0);
        check({pfx, "_rst_lmt"}, 32'(rst_lmt),    0);
        check({pfx, "_cause"},   32'(fail_cause), 0);
        check({pfx, "_cnt"},     32'(fail_cnt),   0);
        check({pfx, "_cfg_err"}, 32'(cfg_err),    0);
    endtask

    initial begin
        #2000000;
        $display("FAIL sim_timeout: got expired expected finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int nf;
        logic [1:0] prev;

        rst        = 1'b1;
        en         = 1'b0;
        kick       = 1'b0;
        timeout    = '0;
        win_open   = '0;
        rst_lmt_in = '0;
        dc_en      = 1'b0;
        rstout_drv = 1'b0;
        step();
        step();
        check_reset_vals("por");

        // ---------------- timeout with downcounter acknowledge ----------------
        rst        = 1'b0;
        timeout    = 16'd10;
        win_open   = 16'd0;
        rst_lmt_in = 16'h000A;
        dc_en      = 1'b1;
        en         = 1'b1;
        step();
        check("to_arm_state",   32'(state),   32'(ST_ARMED));
        check("to_arm_rst_lmt", 32'(rst_lmt), 32'h000A);
        repeat (9) step();
        check("to_pre_state",   32'(state),  32'(ST_ARMED));
        check("to_pre_wdfail",  32'(wdfail), 0);
        step();
        check("to_fail_state",  32'(state),      32'(ST_FAIL));
        check("to_fail_wdfail", 32'(wdfail),     1);
        check("to_fail_cause",  32'(fail_cause), 1);
        check("to_fail_cnt",    32'(fail_cnt),   1);
        step();
        check("to_wait_state",  32'(state),  32'(ST_FAIL));
        check("to_wait_wdfail", 32'(wdfail), 1);
        step();
        check("to_ack_state",   32'(state),  32'(ST_HOLD));
        check("to_ack_wdfail",  32'(wdfail), 0);
        repeat (12) step();
        check("to_hold_state",  32'(state), 32'(ST_HOLD));
        step();
        check("to_rearm_state", 32'(state),      32'(ST_ARMED));
        check("to_rearm_cause", 32'(fail_cause), 1);
        en = 1'b0;
        step();
        check("to_dis_state",   32'(state), 32'(ST_IDLE));
        dc_en = 1'b0;

        // ---------------- legal kicks ----------------
        do_reset();
        timeout  = 16'd10;
        win_open = 16'd3;
        en       = 1'b1;
        step();
        check("lk_arm_state", 32'(state), 32'(ST_ARMED));
        for (int i = 0; i < 17; i++) begin
            repeat (5) step();
            kick = 1'b1;
            step();
            kick = 1'b0;
            check("lk_state",  32'(state),  32'(ST_ARMED));
            check("lk_wdfail", 32'(wdfail), 0);
        end
        repeat (9) step();
        kick = 1'b1;
        step();
        kick = 1'b0;
        check("lk_t9_state", 32'(state), 32'(ST_ARMED));
        repeat (9) step();
        check("lk_after_state",  32'(state),  32'(ST_ARMED));
        check("lk_after_wdfail", 32'(wdfail), 0);
        step();
        check("lk_to_state", 32'(state),      32'(ST_FAIL));
        check("lk_to_cause", 32'(fail_cause), 1);

        // ---------------- early kick ----------------
        do_reset();
        timeout  = 16'd10;
        win_open = 16'd5;
        en       = 1'b1;
        step();
        step();
        step();
        check("ek_pre_state",  32'(state),  32'(ST_ARMED));
        check("ek_pre_wdfail", 32'(wdfail), 0);
        kick = 1'b1;
        step();
        kick = 1'b0;
        check("ek_state",  32'(state),      32'(ST_FAIL));
        check("ek_wdfail", 32'(wdfail),     1);
        check("ek_cause",  32'(fail_cause), 2);
        check("ek_cnt",    32'(fail_cnt),   1);

        // kick exactly at tick == WIN_OPEN is legal
        do_reset();
        en = 1'b1;
        step();
        repeat (5) step();
        kick = 1'b1;
        step();
        kick = 1'b0;
        check("ek_edge_state", 32'(state), 32'(ST_ARMED));

        // ---------------- bad config / disable ----------------
        do_reset();
        timeout  = 16'd0;
        win_open = 16'd0;
        en       = 1'b1;
        step();
        check("cfg_t0_state", 32'(state),   32'(ST_IDLE));
        check("cfg_t0_err",   32'(cfg_err), 1);
        timeout  = 16'd10;
        win_open = 16'd12;
        step();
        check("cfg_w12_state", 32'(state),   32'(ST_IDLE));
        check("cfg_w12_err",   32'(cfg_err), 1);
        win_open = 16'd10;
        step();
        check("cfg_weq_state", 32'(state),   32'(ST_IDLE));
        win_open   = 16'd3;
        rst_lmt_in = 16'h0021;
        step();
        check("cfg_ok_state",   32'(state),   32'(ST_ARMED));
        check("cfg_ok_err",     32'(cfg_err), 0);
        check("cfg_ok_rst_lmt", 32'(rst_lmt), 32'h0021);
        timeout    = 16'd2;
        win_open   = 16'd9;
        rst_lmt_in = 16'h0055;
        repeat (5) step();
        check("cfg_lat_state",   32'(state),   32'(ST_ARMED));
        check("cfg_lat_rst_lmt", 32'(rst_lmt), 32'h0021);
        kick = 1'b1;
        step();
        kick = 1'b0;
        check("cfg_lat_kick", 32'(state), 32'(ST_ARMED));
        repeat (3) step();
        en = 1'b0;
        step();
        check("dis_state",  32'(state),    32'(ST_IDLE));
        check("dis_wdfail", 32'(wdfail),   0);
        check("dis_cnt",    32'(fail_cnt), 0);

        // ---------------- no acknowledge ----------------
        do_reset();
        rstout_drv = 1'b0;
        timeout    = 16'd10;
        win_open   = 16'd0;
        rst_lmt_in = 16'h000A;
        en         = 1'b1;
        step();
        repeat (9) step();
        step();
        check("na_fail_state",  32'(state),  32'(ST_FAIL));
        check("na_fail_wdfail", 32'(wdfail), 1);
        repeat (ACK_TMO - 1) step();
        check("na_last_state",  32'(state),  32'(ST_FAIL));
        check("na_last_wdfail", 32'(wdfail), 1);
        step();
        check("na_hold_state",  32'(state),      32'(ST_HOLD));
        check("na_hold_wdfail", 32'(wdfail),     0);
        check("na_hold_cause",  32'(fail_cause), 3);
        repeat (3) step();
        check("na_hold2_state", 32'(state), 32'(ST_HOLD));
        step();
        check("na_rearm_state", 32'(state),      32'(ST_ARMED));
        check("na_rearm_cause", 32'(fail_cause), 3);
        check("na_rearm_cnt",   32'(fail_cnt),   1);

        // ---------------- saturation, then reset during FAIL ----------------
        do_reset();
        timeout  = 16'd1;
        win_open = 16'd0;
        en       = 1'b1;
        nf       = 0;
        prev     = state;
        for (int c = 0; c < 30000 && nf < 300; c++) begin
            step();
            if (state == ST_FAIL && prev != ST_FAIL) begin
                nf++;
                if (nf == 200) check("sat_200", 32'(fail_cnt), 200);
                if (nf == 255) check("sat_255", 32'(fail_cnt), 255);
                if (nf == 256) check("sat_256", 32'(fail_cnt), 255);
            end
            prev = state;
        end
        check("sat_entries", 32'(nf),       300);
        check("sat_cnt",     32'(fail_cnt), 255);
        check("sat_state",   32'(state),    32'(ST_FAIL));
        rst = 1'b1;
        step();
        check_reset_vals("mid_rst");
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wdt_controller.md
Name: wdt_controller

Overview:
- Window-watchdog sequencer that supervises software "kicks" and drives the downcounter reset-pulse generator (WDFAIL / RST_LMT in, RSTOUT back).
- Detects timeout and early-kick violations, raises WDFAIL, waits for the downcounter's reset pulse to complete, then re-arms after a holdoff.
- Sits between the CPU-side control bits and the downcounter in the safety-reset path.

Parameters:
- CW, 16, width of timeout/window/reset-limit fields and internal tick counter.
- HOLDOFF, 4, cycles RSTOUT_IN must stay low after the pulse before re-arming.
- ACK_TMO, 1024, max cycles in FAIL waiting for RSTOUT_IN to rise.

Ports:
- CLK  in  1  system clock; all logic rising-edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  watchdog enable (level).
- KICK  in  1  single-cycle service strobe.
- TIMEOUT  in  CW  kick deadline in cycles; sampled on arm.
- WIN_OPEN  in  CW  earliest legal kick count; sampled on arm.
- RST_LMT_IN  in  CW  reset pulse length request; sampled on arm.
- RSTOUT_IN  in  1  RSTOUT feedback from downcounter.
- WDFAIL  out  1  to downcounter WDFAIL.
- RST_LMT  out  CW  to downcounter RST_LMT (latched copy).
- STATE  out  2  00 IDLE, 01 ARMED, 10 FAIL, 11 HOLDOFF.
- FAIL_CAUSE  out  2  00 none, 01 timeout, 10 early kick, 11 no ack.
- FAIL_CNT  out  8  saturating count of FAIL entries.
- CFG_ERR  out  1  sticky: arm refused due to bad config.

Behaviour:
- Reset (RST=1 at edge): STATE=IDLE, WDFAIL=0, RST_LMT=0, FAIL_CAUSE=0, FAIL_CNT=0, CFG_ERR=0, tick=0, holdoff count=0. RST dominates all other inputs.
- IDLE:
  - EN=1 with TIMEOUT!=0 and WIN_OPEN<TIMEOUT: latch TIMEOUT, WIN_OPEN and RST_LMT_IN (RST_LMT updates same edge), clear CFG_ERR, tick=0, go ARMED.
  - EN=1 with bad config: set CFG_ERR, stay IDLE.
  - WIN_OPEN=0 means no window; any kick is legal.
- ARMED: tick increments by 1 per cycle. Priority per cycle, highest first:
  1. EN=0 -> IDLE, tick=0, no fail.
  2. KICK=1 with tick<WIN_OPEN -> FAIL, cause=10.
  3. KICK=1 with tick>=WIN_OPEN -> tick=0, stay ARMED. A kick at tick==TIMEOUT-1 is legal and beats the timeout.
  4. tick==TIMEOUT-1 with no kick -> FAIL, cause=01. With TIMEOUT=N and no kicks, FAIL is entered N cycles after ARMED entry.
- Latched config is fixed while ARMED; input changes are ignored until the next arm.
- FAIL entry:
  - WDFAIL=1 registered, first asserted on the cycle after the violating edge.
  - FAIL_CNT+1, saturating at 255.
  - ack timer=0.
- FAIL:
  - RSTOUT_IN=1 sampled -> WDFAIL=0, go HOLDOFF.
  - Ack timer reaches ACK_TMO-1 with no RSTOUT_IN -> cause=11, WDFAIL=0, HOLDOFF.
  - EN is ignored in FAIL; a fail always completes.
- HOLDOFF:
  - Counter clears whenever RSTOUT_IN=1 and increments while RSTOUT_IN=0.
  - At HOLDOFF consecutive low cycles: EN=1 -> re-arm with fresh config sampling (same checks as IDLE); EN=0 -> IDLE.
  - KICK is ignored in HOLDOFF.
- FAIL_CAUSE holds its value until the next FAIL entry or reset.
- RST_LMT holds its value outside the arm event.
- Only legal STATE encodings are reachable; any illegal encoding recovers to IDLE.

Test Plan:
- Timeout: TIMEOUT=10, WIN_OPEN=0, RST_LMT_IN=0x0A, EN=1, no kicks, RSTOUT_IN driven by a downcounter instance -> STATE=10 after 10 ARMED cycles, WDFAIL high until RSTOUT_IN rises, FAIL_CAUSE=01, FAIL_CNT=1, re-arm 4 cycles after RSTOUT_IN falls.
- Legal kicks: TIMEOUT=10, WIN_OPEN=3, KICK every 6 cycles for 100 cycles -> never leaves ARMED, WDFAIL=0; a kick at tick=9 also keeps ARMED.
- Early kick: TIMEOUT=10, WIN_OPEN=5, KICK at tick=2 -> FAIL, cause=10, WDFAIL=1 the next cycle.
- Bad config / disable: TIMEOUT=0 with EN=1 -> CFG_ERR=1, STATE=IDLE. Then WIN_OPEN=12, TIMEOUT=10 -> still IDLE. Then valid config -> ARMED and CFG_ERR=0. EN=0 mid-count -> IDLE, no WDFAIL.
- No ack: RSTOUT_IN tied 0, timeout fail -> WDFAIL high exactly ACK_TMO cycles, cause=11, HOLDOFF, then re-arm.
- Reset mid-operation / saturation: RST during FAIL -> next cycle all outputs at reset values. Force 300 fails -> FAIL_CNT=255.
